// File: rtl/class_top2_if.sv
// Handshake bundle for the top-2 classifier: a score stream in, a result out.
// The slave modport is the classifier's view; master is the source/sink side.
interface class_top2_if #(
    parameter int N_CLASS = 10
);
    localparam int IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

    // Score stream into the classifier
    logic             valid_in;
    logic             ready_out;
    logic [31:0]      class_in;

    // Result stream out of the classifier
    logic             valid_out;
    logic             ready_in;
    logic [IDX_W-1:0] idx0;
    logic [31:0]      val0;
    logic [IDX_W-1:0] idx1;
    logic [31:0]      val1;
    logic             err;

    modport slave (
        input  valid_in, class_in, ready_in,
        output ready_out, valid_out, idx0, val0, idx1, val1, err
    );

    modport master (
        output valid_in, class_in, ready_in,
        input  ready_out, valid_out, idx0, val0, idx1, val1, err
    );
endinterface

// File: rtl/class_top2.sv
// Streaming top-2 classifier over N_CLASS float32 scores per frame.
// Ranking uses an order-preserving integer key of the raw IEEE-754 bits, so no
// floating-point arithmetic is needed. NaN keys sit below -inf and flag err.
module class_top2 #(
    parameter int N_CLASS = 10
) (
    input  logic         clk,
    input  logic         resetn,
    class_top2_if.slave  bus
);
    localparam int IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    typedef enum logic {ACC, OUT} state_t;

    typedef struct packed {
        logic             full;
        logic [IDX_W-1:0] idx;
        logic [31:0]      val;
    } slot_t;

    // NaN: all-ones exponent with a non-zero mantissa
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Unsigned key that orders -inf < negatives < -0 < +0 < positives < +inf
    function automatic logic [31:0] key_of(input logic [31:0] x);
        if (is_nan(x))
            return 32'd0;
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    slot_t            s0_q, s0_d, s1_q, s1_d;
    logic             nan_q, nan_d;
    logic             ready_out_q, ready_out_d;
    logic             valid_out_q, valid_out_d;
    logic [IDX_W-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
    logic [31:0]      val0_q, val0_d, val1_q, val1_d;
    logic             err_q, err_d;

    logic [31:0]      beat_key, k0, k1;
    logic             accept;
    slot_t            beat;

    // Next-state: slot insertion on each accepted beat, result capture on the last
    always_comb begin
        // NOTE: every signal gets a default here so no path through the
        // case/if tree can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        nan_d       = nan_q;
        ready_out_d = ready_out_q;
        valid_out_d = valid_out_q;
        idx0_d      = idx0_q;
        val0_d      = val0_q;
        idx1_d      = idx1_q;
        val1_d      = val1_q;
        err_d       = err_q;

        beat_key  = key_of(bus.class_in);
        k0        = key_of(s0_q.val);
        k1        = key_of(s1_q.val);
        accept    = bus.valid_in && ready_out_q;
        beat.full = 1'b1;
        beat.idx  = cnt_q;
        beat.val  = bus.class_in;

        case (state_q)
            OUT: begin
                if (bus.ready_in) begin
                    state_d     = ACC;
                    valid_out_d = 1'b0;
                    ready_out_d = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    nan_d = nan_q | is_nan(bus.class_in);
                    // Strict compares keep the earlier index on ties; an empty
                    // slot loses to anything, NaN included.
                    if (!s0_q.full || (beat_key > k0)) begin
                        s1_d = s0_q;
                        s0_d = beat;
                    end else if (!s1_q.full || (beat_key > k1)) begin
                        s1_d = beat;
                    end

                    if (cnt_q == LAST_IDX) begin
                        idx0_d      = s0_d.idx;
                        val0_d      = s0_d.val;
                        idx1_d      = s1_d.idx;
                        val1_d      = s1_d.val;
                        err_d       = nan_d;
                        state_d     = OUT;
                        valid_out_d = 1'b1;
                        ready_out_d = 1'b0;
                        cnt_d       = '0;
                        s0_d.full   = 1'b0;
                        s1_d.full   = 1'b0;
                        nan_d       = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State, accumulator and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            nan_q       <= 1'b0;
            ready_out_q <= 1'b1;
            valid_out_q <= 1'b0;
            idx0_q      <= '0;
            val0_q      <= '0;
            idx1_q      <= '0;
            val1_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            nan_q       <= nan_d;
            ready_out_q <= ready_out_d;
            valid_out_q <= valid_out_d;
            idx0_q      <= idx0_d;
            val0_q      <= val0_d;
            idx1_q      <= idx1_d;
            val1_q      <= val1_d;
            err_q       <= err_d;
        end
    end

    assign bus.ready_out = ready_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.idx0      = idx0_q;
    assign bus.val0      = val0_q;
    assign bus.idx1      = idx1_q;
    assign bus.val1      = val1_q;
    assign bus.err       = err_q;
endmodule
